dbus_bridge: RTL
================

Name: dbus_bridge

Overview:
- Sits directly downstream of the load/store unit, between the LSU's data-bus request signals and the data memory / peripheral bus.
- Registers each LSU load or store request and drives a single-outstanding, Wishbone-style classic cycle (cyc/stb/we/sel).
- Steers store data into the correct byte lanes and returns a one-cycle ack with the full read word; the LSU does load byte/halfword extraction itself.
- Handles pipeline flushes, and bus timeouts via an error-terminated ack.

Parameters:
- XLEN, 32, data/address width (only 32 supported).
- TIMEOUT_CYCLES, 255, max bus wait cycles before error termination; must be >= 1.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-high: asserted when 1, despite the name.
- lsu_addr_i  input  32  load/store byte address.
- lsu_wdata_i  input  32  store data, unaligned (rs2 value).
- lsu_ld_req_i  input  1  load request, level, held until ack.
- lsu_st_req_i  input  1  store request, level, held until ack.
- lsu_st_ops_i  input  2  store size: 0 none, 1 SB, 2 SH, 3 SW.
- lsu_flush_i  input  1  pipeline flush.
- lsu_ack_o  output  1  one-cycle completion pulse to LSU.
- lsu_rdata_o  output  32  registered read word, valid while lsu_ack_o=1.
- lsu_err_o  output  1  bus timeout flag, valid with lsu_ack_o.
- mem_cyc_o  output  1  bus cycle active.
- mem_stb_o  output  1  bus strobe.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_sel_o  output  4  byte-lane enables.
- mem_wdata_o  output  32  lane-steered write data.
- mem_ack_i  input  1  bus acknowledge.
- mem_rdata_i  input  32  bus read data, valid with mem_ack_i.

Behaviour:
- FSM states: IDLE, BUSY, RESP, DRAIN.
- Reset (rst_n=1, synchronous, overrides all other inputs): state=IDLE. The following are 0: cyc, stb, we, sel, addr, wdata, lsu_ack_o, lsu_rdata_o, lsu_err_o, timeout counter.
- IDLE:
  - If (lsu_ld_req_i|lsu_st_req_i) & !lsu_flush_i: latch address, we=lsu_st_req_i, sel, steered wdata. Assert cyc=stb=1 next cycle; go BUSY; counter cleared.
  - Store has priority if both requests are high; the load is ignored.
  - A store with st_ops=0 is treated as no request.
- Load sel=4'hF, wdata=0.
- Store lane steering:
  - SB: sel=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: sel=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}; addr[0] ignored.
  - SW: sel=4'hF, wdata=wdata; addr[1:0] ignored. Misalignment is trapped upstream.
- BUSY:
  - Outputs held stable; counter increments every cycle without ack.
  - On mem_ack_i: drop cyc/stb next cycle; capture mem_rdata_i (0 for stores); go RESP.
  - If counter reaches TIMEOUT_CYCLES without ack: drop cyc/stb; rdata=0; err=1; go RESP.
  - mem_ack_i and timeout in the same cycle: ack wins, err=0.
  - lsu_flush_i=1 without mem_ack_i: go DRAIN; the bus cycle is not aborted.
  - lsu_flush_i=1 together with mem_ack_i: go IDLE with no lsu_ack_o; the transaction is discarded.
- RESP: lsu_ack_o=1 for exactly one cycle with lsu_rdata_o/lsu_err_o valid; then IDLE. New requests are not sampled in RESP.
- DRAIN:
  - cyc/stb held until mem_ack_i or timeout, then IDLE.
  - lsu_ack_o never asserted; flush input ignored.
- Latency: request first seen in IDLE at cycle N → stb at N+1. mem_ack_i at cycle M (M≥N+1) → lsu_ack_o at M+1. Zero-wait bus gives 2 cycles request-to-ack.
- lsu_ack_o is never asserted in two consecutive cycles. At most one outstanding transaction.
- Inputs are not re-sampled during BUSY/RESP/DRAIN; changes to them have no effect.

Test Plan:
- Reset with all inputs toggling, rst_n=1 for 2 cycles → every output 0, state IDLE; first request accepted on the cycle after rst_n falls.
- Load, addr=0x1000_0006, zero-wait memory returning 0xA1B2C3D4 → stb at N+1 with mem_addr_o=0x1000_0004, sel=4'hF, we=0; lsu_ack_o at N+2 with lsu_rdata_o=0xA1B2C3D4, err=0.
- Stores SB addr=…3 wdata=0x000000EE; SH addr=…2 wdata=0x0000BEEF → sel=4'b1000, mem_wdata_o=0xEEEEEEEE; then sel=4'b1100, mem_wdata_o=0xBEEFBEEF, we=1.
- Memory with 3 wait states → stb held 4 cycles with stable addr/sel/wdata; exactly one lsu_ack_o pulse, one cycle after mem_ack_i.
- No mem_ack_i, TIMEOUT_CYCLES=4 → cyc/stb drop after 4 BUSY cycles; lsu_ack_o=1, lsu_err_o=1, lsu_rdata_o=0.
- Flush asserted in BUSY, mem_ack_i two cycles later → state DRAIN; cyc held until ack; no lsu_ack_o; next request accepted from IDLE.

Source files
------------

// File: rtl/dbus_bridge.sv
// LSU-to-data-bus bridge: registers one load/store at a time and runs a
// Wishbone-style classic cycle with byte-lane steering, flush and timeout handling.
module dbus_bridge #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic            lsu_ld_req_i,
  input  logic            lsu_st_req_i,
  input  logic [1:0]      lsu_st_ops_i,
  input  logic            lsu_flush_i,
  output logic            lsu_ack_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_err_o,
  output logic            mem_cyc_o,
  output logic            mem_stb_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_sel_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             st_go_c;
  logic             req_go_c;
  logic [3:0]       req_sel_c;
  logic [XLEN-1:0]  req_wdata_c;
  logic             timeout_c;

  // Request decode and store-lane steering; a zero-size store is no request.
  always_comb begin
    st_go_c     = lsu_st_req_i && (lsu_st_ops_i != 2'd0);
    req_go_c    = (st_go_c || lsu_ld_req_i) && !lsu_flush_i;
    req_sel_c   = 4'hF;
    req_wdata_c = '0;
    if (st_go_c) begin
      case (lsu_st_ops_i)
        2'd1: begin
          req_sel_c   = 4'b0001 << lsu_addr_i[1:0];
          req_wdata_c = {4{lsu_wdata_i[7:0]}};
        end
        2'd2: begin
          req_sel_c   = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
          req_wdata_c = {2{lsu_wdata_i[15:0]}};
        end
        default: begin
          req_sel_c   = 4'hF;
          req_wdata_c = lsu_wdata_i;
        end
      endcase
    end
  end

  assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_cyc_o   <= 1'b0;
      mem_stb_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_sel_o   <= '0;
      mem_wdata_o <= '0;
      lsu_ack_o   <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_go_c) begin
            state       <= BUSY;
            cnt         <= '0;
            mem_cyc_o   <= 1'b1;
            mem_stb_o   <= 1'b1;
            mem_we_o    <= st_go_c;
            mem_addr_o  <= {lsu_addr_i[XLEN-1:2], 2'b00};
            mem_sel_o   <= req_sel_c;
            mem_wdata_o <= req_wdata_c;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            // A flush landing on the ack discards the completed transaction.
            if (lsu_flush_i) begin
              state <= IDLE;
            end else begin
              state       <= RESP;
              lsu_ack_o   <= 1'b1;
              lsu_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
              lsu_err_o   <= 1'b0;
            end
          end else if (timeout_c) begin
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
            if (lsu_flush_i) begin
              state <= IDLE;
            end else begin
              state       <= RESP;
              lsu_ack_o   <= 1'b1;
              lsu_rdata_o <= '0;
              lsu_err_o   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (lsu_flush_i) begin
              state <= DRAIN;
            end
          end
        end
        RESP: begin
          lsu_ack_o <= 1'b0;
          state     <= IDLE;
        end
        DRAIN: begin
          // Let the orphaned bus cycle finish so the slave sees a clean handshake.
          if (mem_ack_i || timeout_c) begin
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
